// File: rtl/mask_load_scheduler_pkg.sv
// Shared definitions for the mask load scheduler.
//   DefaultCntW : default width of the subframe count / index
//   state_e     : scheduler state encoding
package mask_load_scheduler_pkg;

  localparam int unsigned DefaultCntW = 32;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStream = 3'd1,
    StSettle = 3'd2,
    StLatch  = 3'd3,
    StAck    = 3'd4,
    StError  = 3'd5
  } state_e;

endpackage

// File: rtl/mask_load_scheduler.sv
// Sequences one burst of ROWS pattern-FIFO reads per subframe into the mask shift chain,
// waits SETTLE cycles, strobes mask_latch, then completes a 4-phase req/ack handshake
// with the exposure FSM.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   abort        : sync; returns to idle and clears subframe index / error
//   num_subc     : subframes per frame (0 behaves as 1)
//   load_req     : level request for the next mask
//   load_ack     : held after latch until load_req is seen low
//   fifo_empty   : pattern FIFO empty
//   fifo_rd      : pattern FIFO read enable
//   mask_latch   : one-cycle mask transfer strobe
//   subc_cnt     : index of the subframe currently loaded
//   frame_tick   : one-cycle pulse when subc_cnt wraps to 0
//   busy         : scheduler active (not idle, not in error)
//   underrun     : sticky stall error, cleared only by abort or reset
module mask_load_scheduler
  import mask_load_scheduler_pkg::*;
#(
  parameter int unsigned ROWS      = 320,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned MAX_STALL = 255,
  parameter int unsigned CNT_W     = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_subc,
  input  logic             load_req,
  output logic             load_ack,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             mask_latch,
  output logic [CNT_W-1:0] subc_cnt,
  output logic             frame_tick,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned RowW    = $clog2(ROWS + 1);
  localparam int unsigned StallW  = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [RowW-1:0]    RowLast    = RowW'(ROWS - 1);
  localparam logic [StallW-1:0]  StallMax   = StallW'(MAX_STALL);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [StallW-1:0]  stall_q, stall_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]   subc_q, subc_d;
  logic [CNT_W-1:0]   subc_last;
  logic               wrap;

  // num_subc == 0 behaves as a one-subframe frame.
  assign subc_last = (num_subc == '0) ? '0 : num_subc - 1'b1;
  // >= so that a mid-frame reduction of num_subc wraps immediately.
  assign wrap      = (subc_q >= subc_last);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    stall_d    = stall_q;
    settle_d   = settle_q;
    subc_d     = subc_q;
    fifo_rd    = 1'b0;
    mask_latch = 1'b0;
    frame_tick = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_req) begin
          state_d = StStream;
          row_d   = '0;
          stall_d = '0;
        end
      end
      StStream: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          stall_d = '0;
          row_d   = row_q + 1'b1;
          if (row_q == RowLast) begin
            state_d  = StSettle;
            settle_d = '0;
          end
        end else if (stall_q == StallMax) begin
          state_d = StError;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StLatch;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StLatch: begin
        mask_latch = 1'b1;
        frame_tick = wrap;
        subc_d     = wrap ? '0 : subc_q + 1'b1;
        state_d    = StAck;
      end
      StAck: begin
        if (!load_req) begin
          state_d = StIdle;
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides every concurrent event, including reads and the latch strobe.
    if (abort) begin
      state_d    = StIdle;
      row_d      = '0;
      stall_d    = '0;
      settle_d   = '0;
      subc_d     = '0;
      fifo_rd    = 1'b0;
      mask_latch = 1'b0;
      frame_tick = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      stall_q  <= '0;
      settle_q <= '0;
      subc_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      stall_q  <= stall_d;
      settle_q <= settle_d;
      subc_q   <= subc_d;
    end
  end

  // Status outputs decode the state register, so an async reset clears them at once.
  assign load_ack = (state_q == StAck);
  assign busy     = state_q inside {StStream, StSettle, StLatch, StAck};
  assign underrun = (state_q == StError);
  assign subc_cnt = subc_q;

endmodule

// File: tb/tb_mask_load_scheduler.sv
// Self-checking bench for mask_load_scheduler (ROWS=4, SETTLE=2, MAX_STALL=255).
module tb_mask_load_scheduler;

  localparam int unsigned ROWS      = 4;
  localparam int unsigned SETTLE    = 2;
  localparam int unsigned MAX_STALL = 255;
  localparam int unsigned CNT_W     = 32;
  localparam int          Budget    = 2000;

  logic             clk;
  logic             rst_n;
  logic             abort;
  logic [CNT_W-1:0] num_subc;
  logic             load_req;
  logic             load_ack;
  logic             fifo_empty;
  logic             fifo_rd;
  logic             mask_latch;
  logic [CNT_W-1:0] subc_cnt;
  logic             frame_tick;
  logic             busy;
  logic             underrun;

  int vectors;
  int miscompares;
  int n_latch;  // latches since last clear of the subframe index

  mask_load_scheduler #(
    .ROWS     (ROWS),
    .SETTLE   (SETTLE),
    .MAX_STALL(MAX_STALL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .num_subc  (num_subc),
    .load_req  (load_req),
    .load_ack  (load_ack),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .mask_latch(mask_latch),
    .subc_cnt  (subc_cnt),
    .frame_tick(frame_tick),
    .busy      (busy),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_subc(input logic [CNT_W-1:0] n);
    return (n == '0) ? 1 : int'(n);
  endfunction

  // Expected subframe index: latches modulo the effective frame length.
  function automatic logic [31:0] exp_subc();
    return 32'(n_latch % eff_subc(num_subc));
  endfunction

  // One full request: burst with optional FIFO gaps, settle, latch, handshake.
  // mode 0: FIFO never empty; 1: random empties; 2: gap_len empty cycles after 2nd word.
  task automatic run_burst(input int mode, input int gap_len, input bit drop_early);
    int  reads, last, gap_cnt, hold;
    bit  empty, exp_rd, exp_latch, done;
    reads = 0; last = 0; gap_cnt = 0; done = 0;
    @(posedge clk); #1;
    load_req   = 1'b1;
    fifo_empty = 1'b0;
    #1;
    check_val("idle_rd", fifo_rd, 0);
    for (int c = 1; c <= Budget && !done; c++) begin
      @(posedge clk); #1;
      empty = 1'b0;
      if (reads < ROWS) begin
        if (mode == 1) begin
          empty = ($urandom_range(0, 3) == 0);
        end else if (mode == 2 && reads == 2 && gap_cnt < gap_len) begin
          empty = 1'b1;
          gap_cnt++;
        end
      end
      fifo_empty = empty;
      if (drop_early && c == 2) load_req = 1'b0;
      #1;
      exp_rd    = (reads < ROWS) && !empty;
      exp_latch = (reads == ROWS) && (c == last + SETTLE + 1);
      check_val("fifo_rd", fifo_rd, exp_rd);
      check_val("mask_latch", mask_latch, exp_latch);
      check_val("busy", busy, 1);
      check_val("load_ack_burst", load_ack, 0);
      if (exp_latch) begin
        check_val("frame_tick", frame_tick, ((n_latch + 1) % eff_subc(num_subc)) == 0);
        n_latch++;
        done = 1'b1;
      end else begin
        check_val("frame_tick_idle", frame_tick, 0);
      end
      if (exp_rd) begin
        reads++;
        last = c;
      end
    end
    if (!done) check_val("burst_timeout", 0, 1);
    // First ACK cycle
    @(posedge clk); #2;
    check_val("load_ack", load_ack, 1);
    check_val("subc_cnt", subc_cnt, exp_subc());
    check_val("latch_once", mask_latch, 0);
    if (!drop_early) begin
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk); #2;
        check_val("ack_hold", load_ack, 1);
      end
      @(posedge clk); #1;
      load_req = 1'b0;
      #1;
      check_val("ack_until_req_low", load_ack, 1);
    end
    @(posedge clk); #2;
    check_val("ack_drop", load_ack, 0);
    check_val("idle_busy", busy, 0);
  endtask

  task automatic run_underrun();
    @(posedge clk); #1;
    load_req   = 1'b1;
    fifo_empty = 1'b0;
    repeat (2) begin
      @(posedge clk); #2;
      check_val("ur_read", fifo_rd, 1);
    end
    // 256 consecutive empty cycles: the last one exceeds the tolerance.
    for (int k = 0; k < MAX_STALL + 1; k++) begin
      @(posedge clk); #1;
      fifo_empty = 1'b1;
      #1;
      check_val("ur_stall_rd", fifo_rd, 0);
      check_val("ur_not_yet", underrun, 0);
    end
    @(posedge clk); #1;
    fifo_empty = 1'b0;
    #1;
    check_val("ur_flag", underrun, 1);
    check_val("ur_no_rd", fifo_rd, 0);
    check_val("ur_busy", busy, 0);
    check_val("ur_ack", load_ack, 0);
    repeat (6) begin
      @(posedge clk); #2;
      check_val("ur_sticky", underrun, 1);
      check_val("ur_no_latch", mask_latch, 0);
    end
    @(posedge clk); #1;
    abort    = 1'b1;
    load_req = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    n_latch = 0;
    check_val("abort_underrun", underrun, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_subc", subc_cnt, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_latch     = 0;
    rst_n       = 1'b0;
    abort       = 1'b0;
    num_subc    = 3;
    load_req    = 1'b0;
    fifo_empty  = 1'b0;
    #2;
    check_val("rst_fifo_rd", fifo_rd, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ack", load_ack, 0);
    check_val("rst_latch", mask_latch, 0);
    check_val("rst_tick", frame_tick, 0);
    check_val("rst_underrun", underrun, 0);
    check_val("rst_subc", subc_cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Seven subframes at num_subc=3: index 1,2,0,1,2,0,1.
    for (int i = 0; i < 7; i++) begin
      run_burst((i == 0) ? 0 : 1, 0, (i == 3));
    end
    run_burst(2, 10, 1'b0);
    run_burst(2, MAX_STALL, 1'b0);
    run_burst(1, 0, 1'b0);

    run_underrun();

    num_subc = 0;
    for (int i = 0; i < 3; i++) run_burst(1, 0, 1'b0);

    num_subc = 3;
    n_latch  = 0;
    run_burst(0, 0, 1'b0);

    // Async reset between edges while streaming.
    @(posedge clk); #1;
    load_req   = 1'b1;
    fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check_val("pre_rst_rd", fifo_rd, 1);
    rst_n = 1'b0;
    #1;
    n_latch = 0;
    check_val("arst_rd", fifo_rd, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_subc", subc_cnt, 0);
    check_val("arst_ack", load_ack, 0);
    check_val("arst_latch", mask_latch, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    load_req = 1'b0;
    @(posedge clk); #2;
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_rd", fifo_rd, 0);
    run_burst(0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
